// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (output start, op, a, b, cancel,
                    input  busy, done, hi, lo, div_zero);
    modport slave  (input  start, op, a, b, cancel,
                    output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply and radix-2 restoring divide with start/busy/done/cancel.
// state   | meaning
// IDLE    | waiting for start
// MUL     | product moving through MUL_STAGES+1 cycles
// DIV_RUN | one quotient bit per cycle on magnitudes, or divide-by-zero shortcut
// DIV_FIX | apply quotient/remainder signs
// DONE    | one-cycle done pulse; a new start may be accepted here
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 1
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_RUN, S_DIV_FIX, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic               sgn_r, neg_q, neg_r;
    logic [WIDTH-1:0]   a_r, b_r, dvs, rem, quo;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
    logic [WIDTH:0]     shifted, diff;
    logic               in_sgn;
    logic [WIDTH-1:0]   in_abs_a, in_abs_b;

    assign accept   = bus.start && !bus.cancel && (state == S_IDLE || state == S_DONE);
    assign in_sgn   = !bus.op[0];
    assign in_abs_a = (in_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign in_abs_b = (in_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Truncating the product of sign-extended operands to 2*WIDTH gives the signed product.
    assign ext_a = {{WIDTH{sgn_r & a_r[WIDTH-1]}}, a_r};
    assign ext_b = {{WIDTH{sgn_r & b_r[WIDTH-1]}}, b_r};
    assign prod  = ext_a * ext_b;

    generate
        if (MUL_STAGES == 0) begin : g_no_pipe
            assign mul_res = prod;
        end else begin : g_pipe
            logic [2*WIDTH-1:0] pipe [MUL_STAGES];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= prod;
                    for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign mul_res = pipe[MUL_STAGES-1];
        end
    endgenerate

    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = bus.op[1] ? S_DIV_RUN : S_MUL;
            S_MUL:     if (cnt == '0) state_nxt = S_DONE;
            S_DIV_RUN: begin
                if (b_r == '0)      state_nxt = S_DONE;
                else if (cnt == '0) state_nxt = S_DIV_FIX;
            end
            S_DIV_FIX: state_nxt = S_DONE;
            S_DONE:    state_nxt = accept ? (bus.op[1] ? S_DIV_RUN : S_MUL) : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (bus.cancel) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_r        <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            dvs          <= '0;
            rem          <= '0;
            quo          <= '0;
            cnt          <= '0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.div_zero <= 1'b0;
        end else if (accept) begin
            sgn_r <= in_sgn;
            neg_q <= in_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r <= in_sgn && bus.a[WIDTH-1];
            a_r   <= bus.a;
            b_r   <= bus.b;
            dvs   <= in_abs_b;
            quo   <= in_abs_a;
            rem   <= '0;
            cnt   <= bus.op[1] ? CW'(WIDTH-1) : CW'(MUL_STAGES);
        end else if (!bus.cancel) begin
            case (state)
                S_MUL: begin
                    if (cnt == '0) begin
                        {bus.hi, bus.lo} <= mul_res;
                        bus.div_zero     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV_RUN: begin
                    if (b_r == '0) begin
                        bus.hi       <= a_r;
                        bus.lo       <= '1;
                        bus.div_zero <= 1'b1;
                    end else begin
                        if (!diff[WIDTH]) begin
                            rem <= diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV_FIX: begin
                    bus.hi       <= neg_r ? -rem : rem;
                    bus.lo       <= neg_q ? -quo : quo;
                    bus.div_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == S_MUL) || (state == S_DIV_RUN) || (state == S_DIV_FIX);
    assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_STAGES=1) with hand-computed results.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .MUL_STAGES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issues one operation; lat is the cycle (1 = first after acceptance) in which done
    // is seen, -1 on timeout; nbusy counts busy cycles seen before done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int nbusy);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1357_9BDF;
        lat   = -1;
        nbusy = 0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) nbusy++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
            begin errors++; $display("FAIL reset_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_divu();
        int lat, nb;
        run_op(2'b11, 32'd100, 32'd7, lat, nb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency got=%0d exp=34", lat); end
        checks++; if (nb !== 33) begin errors++; $display("FAIL divu_busy_cycles got=%0d exp=33", nb); end
        checks++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || bus.div_zero !== 1'b0)
            begin errors++; $display("FAIL divu_100_7 got hi=%h lo=%h dz=%b exp hi=2 lo=e dz=0", bus.hi, bus.lo, bus.div_zero); end
    endtask

    task automatic test_div_signed();
        int lat, nb;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, nb);
        checks++; if (lat !== 34 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL div_m7_2 got lat=%0d hi=%h lo=%h exp lat=34 hi=ffffffff lo=fffffffd", lat, bus.hi, bus.lo); end
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, nb);
        checks++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'd1)
            begin errors++; $display("FAIL div_7_m2 got hi=%h lo=%h exp hi=1 lo=fffffffd", bus.hi, bus.lo); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        checks++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || bus.div_zero !== 1'b0)
            begin errors++; $display("FAIL div_overflow got hi=%h lo=%h dz=%b exp hi=0 lo=80000000 dz=0", bus.hi, bus.lo, bus.div_zero); end
    endtask

    task automatic test_mult();
        int lat, nb;
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, lat, nb);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mult_latency got=%0d exp=3", lat); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE)
            begin errors++; $display("FAIL mult_m1_2 got hi=%h lo=%h exp hi=ffffffff lo=fffffffe", bus.hi, bus.lo); end
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, lat, nb);
        checks++; if (lat !== 3 || bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE)
            begin errors++; $display("FAIL multu_ffffffff_2 got lat=%0d hi=%h lo=%h exp lat=3 hi=1 lo=fffffffe", lat, bus.hi, bus.lo); end
    endtask

    task automatic test_div_zero();
        int lat, nb;
        run_op(2'b10, 32'd123, 32'd0, lat, nb);
        checks++; if (lat !== 2) begin errors++; $display("FAIL divzero_latency got=%0d exp=2", lat); end
        checks++; if (bus.div_zero !== 1'b1 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd123)
            begin errors++; $display("FAIL divzero_result got hi=%h lo=%h dz=%b exp hi=7b lo=ffffffff dz=1", bus.hi, bus.lo, bus.div_zero); end
        run_op(2'b11, 32'd9, 32'd3, lat, nb);
        checks++; if (bus.div_zero !== 1'b0 || bus.lo !== 32'd3 || bus.hi !== 32'd0)
            begin errors++; $display("FAIL divu_9_3 got hi=%h lo=%h dz=%b exp hi=0 lo=3 dz=0", bus.hi, bus.lo, bus.div_zero); end
    endtask

    task automatic test_cancel();
        int seen_done = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL cancel_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL cancel_no_done got=%0d exp=0", seen_done); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd3)
            begin errors++; $display("FAIL cancel_hold got hi=%h lo=%h exp hi=0 lo=3", bus.hi, bus.lo); end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        run_op(2'b11, 32'd50, 32'd5, lat, nb);
        checks++; if (bus.done !== 1'b1 || bus.lo !== 32'd10 || bus.hi !== 32'd0)
            begin errors++; $display("FAIL b2b_first got done=%b hi=%h lo=%h exp done=1 hi=0 lo=a", bus.done, bus.hi, bus.lo); end
        run_op(2'b01, 32'd6, 32'd7, lat, nb);
        checks++; if (lat !== 3 || nb !== 2)
            begin errors++; $display("FAIL b2b_second_timing got lat=%0d busy=%0d exp lat=3 busy=2", lat, nb); end
        checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0)
            begin errors++; $display("FAIL b2b_second_result got hi=%h lo=%h exp hi=0 lo=2a", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_mid();
        int lat, nb;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0)
            begin errors++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h exp all 0", bus.busy, bus.done, bus.hi, bus.lo); end
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b01, 32'd3, 32'd5, lat, nb);
        checks++; if (lat !== 3 || bus.lo !== 32'd15 || bus.hi !== 32'd0)
            begin errors++; $display("FAIL post_reset_multu got lat=%0d hi=%h lo=%h exp lat=3 hi=0 lo=f", lat, bus.hi, bus.lo); end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        test_reset();
        test_divu();
        test_div_signed();
        test_mult();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage; next generation of the ALU's embedded divider path.
- Performs signed and unsigned WIDTH x WIDTH multiply and divide, returning a 2*WIDTH HI/LO pair.
- Uses an explicit start/busy/done handshake with cancel, so the pipeline stalls only while busy and can flush an in-flight operation on exception or branch squash.

Parameters:
- WIDTH, 32: operand width; results are {hi, lo}, each WIDTH bits.
- MUL_STAGES, 1: extra register stages on the multiplier product (0..3); multiply latency = MUL_STAGES+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- cancel  in  1  synchronous abort of the current operation.
- busy  out  1  operation in flight; the pipeline stalls on busy or on an accepted start.
- done  out  1  one-cycle pulse: hi/lo hold a new result.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- div_zero  out  1  set with done when a divide had b == 0.

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; all internal counters and registers cleared.
- States: IDLE, MUL, DIV_RUN, DIV_FIX, DONE.
- Accept rule: start=1 and cancel=0 while in IDLE or DONE. The unit latches op, a and b at that edge, so back-to-back issue from DONE is allowed.
- Multiply: MUL state lasts MUL_STAGES+1 cycles, then DONE.
  - Signed product uses sign-extended operands; unsigned uses zero-extended operands; result is the full 2*WIDTH product.
  - done is high in the cycle after MUL ends. For MUL_STAGES=1 and acceptance at edge T, done is high in cycle T+3.
- Divide: radix-2 restoring algorithm on absolute values.
  - DIV_RUN runs exactly WIDTH cycles, one quotient bit per cycle; a counter counts WIDTH-1 down to 0.
  - DIV_FIX (1 cycle) applies signs: quotient is negated if sign(a) XOR sign(b); remainder takes the sign of a. DIV_FIX then goes to DONE.
  - done is high WIDTH+2 cycles after acceptance.
- Divide by zero: the iteration is skipped and the unit goes DIV_RUN->DONE in 1 cycle. Result is lo = all ones, hi = a, div_zero=1.
- Signed overflow (a = most negative, b = -1): lo = most negative, hi = 0; div_zero=0.
- DONE lasts 1 cycle with done=1 and busy=0, then goes to IDLE, unless a new start is accepted.
- hi, lo and div_zero are registered and hold their last value until the next done.
- busy=1 in MUL, DIV_RUN and DIV_FIX; busy=0 in IDLE and DONE.
- cancel=1 in any state: next state is IDLE, no done pulse, hi/lo unchanged. cancel takes priority over a simultaneous start.
- Changes on a or b after acceptance have no effect.
- op/a/b are ignored when start=0.
- Reset asserted mid-operation aborts immediately to the reset values; no done pulse is generated.

Test Plan:
- DIVU, WIDTH=32, a=100, b=7, start at edge T -> busy for cycles T+1..T+33; done at T+34 with lo=14, hi=2, div_zero=0.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- MULT a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE. With MUL_STAGES=1, done 3 cycles after acceptance.
- DIV a=123, b=0 -> done 2 cycles after acceptance with div_zero=1, lo=0xFFFFFFFF, hi=123. A following DIVU 9/3 -> div_zero=0, lo=3, hi=0.
- DIVU started, then cancel at cycle T+10 -> IDLE at T+11, no done pulse, hi/lo keep the prior values. Start issued during DONE -> accepted, busy=1 next cycle.
- Assert rst asynchronously mid-DIV_RUN (between clock edges) -> busy, done, hi and lo go to 0 immediately. After release, MULTU 3*5 -> lo=15, hi=0.
